// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the shared-RAM read arbiter: region/lane encodings,
// the return-path tag and the channel-id width helper.
package shared_ram_pkg;

  localparam logic REG_MODEL    = 1'b0;
  localparam logic REG_SPEECH   = 1'b1;
  // Big-endian speech words: the even byte address maps to bits [15:8].
  localparam logic BYTE_HI_EVEN = 1'b1;

  // Sized for the largest supported channel count (8).
  localparam int CH_ID_MAX_W = 3;

  typedef struct packed {
    logic                   vld;
    logic [CH_ID_MAX_W-1:0] ch_id;
    logic                   region;
    logic                   lsb;
  } tag_t;

  function automatic int ch_id_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// Client-side bus of the shared-RAM arbiter: per-channel request/address in,
// grant, read-valid and read-data out (ch_lock only with SHARED_RAM_ARBITER_BURST_EN).
interface shared_ram_arbiter_if #(
  parameter int N_CH = 2,
  parameter int AW   = 21
);
  logic [N_CH-1:0]    ch_req;
  logic [N_CH*AW-1:0] ch_addr;
  logic [N_CH-1:0]    ch_gnt;
  logic [N_CH-1:0]    ch_rvalid;
  logic [N_CH*8-1:0]  ch_rdata;
`ifdef SHARED_RAM_ARBITER_BURST_EN
  logic [N_CH-1:0]    ch_lock;

  modport master (output ch_req, ch_addr, ch_lock, input ch_gnt, ch_rvalid, ch_rdata);
  modport slave  (input ch_req, ch_addr, ch_lock, output ch_gnt, ch_rvalid, ch_rdata);
`else
  modport master (output ch_req, ch_addr, input ch_gnt, ch_rvalid, ch_rdata);
  modport slave  (input ch_req, ch_addr, output ch_gnt, ch_rvalid, ch_rdata);
`endif
endinterface

// File: rtl/shared_ram_arbiter_rr.sv
// Round-robin / fixed-priority arbiter with owner lock; grant is combinational
// (zero latency), no backpressure: one grant per cycle whenever any request is up.
module rr_arbiter import shared_ram_pkg::*; #(
  parameter int   N_CH    = 2,
  parameter bit   RR_MODE = 1'b1,
  localparam int  IDW     = ch_id_w(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] lock,
  output logic [N_CH-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] owner_q;
  logic           owner_vld_q;
  logic           lock_hit;

  always_comb begin
    int base;
    int idx;
    gnt      = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    base     = RR_MODE ? int'(ptr_q) : 0;
    idx      = 0;
    // A locked owner that is still requesting overrides the normal search.
    lock_hit = owner_vld_q && req[owner_q] && lock[owner_q];
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_id  = owner_q;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        idx = base + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else if (gnt_any) begin
      ptr_q       <= (int'(gnt_id) == N_CH - 1) ? '0 : gnt_id + 1'b1;
      owner_q     <= gnt_id;
      owner_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Shares one model/speech RAM read port among N_CH byte clients; grant to rvalid = RD_LAT+1,
// no stall (one read accepted per cycle). SHARED_RAM_ARBITER_BURST_EN adds ch_lock owner bursts.
module shared_ram_arbiter import shared_ram_pkg::*; #(
  parameter int N_CH    = 2,
  parameter int AW      = 21,
  parameter int RD_LAT  = 1,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_ram_arbiter_if.slave   bus,
  output logic                  model_rd,
  output logic [AW-2:0]         model_addr,
  input  logic [7:0]            model_data,
  output logic                  speech_rd,
  output logic [AW-3:0]         speech_addr,
  input  logic [15:0]           speech_data,
  output logic                  busy
);

  localparam int IDW = ch_id_w(N_CH);

  logic [N_CH-1:0] req_eff;
  logic [N_CH-1:0] lock_eff;
  logic [N_CH-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [AW-1:0]   sel_addr;

  // No grants while reset is held, so every output reads 0 during reset.
  assign req_eff = reset ? bus.ch_req : '0;

`ifdef SHARED_RAM_ARBITER_BURST_EN
  assign lock_eff = bus.ch_lock;
`else
  assign lock_eff = '0;
`endif

  rr_arbiter #(.N_CH(N_CH), .RR_MODE(RR_MODE)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_eff),
    .lock    (lock_eff),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign bus.ch_gnt  = gnt;
  assign sel_addr    = bus.ch_addr[int'(gnt_id) * AW +: AW];
  assign model_rd    = gnt_any && (sel_addr[AW-1] == REG_MODEL);
  assign speech_rd   = gnt_any && (sel_addr[AW-1] == REG_SPEECH);
  assign model_addr  = model_rd  ? sel_addr[AW-2:0] : '0;
  assign speech_addr = speech_rd ? sel_addr[AW-2:1] : '0;

  tag_t tag_q [RD_LAT];
  tag_t new_tag;
  tag_t ret_tag;

  always_comb begin
    new_tag        = '0;
    new_tag.vld    = gnt_any;
    new_tag.ch_id  = CH_ID_MAX_W'(gnt_id);
    new_tag.region = sel_addr[AW-1];
    new_tag.lsb    = sel_addr[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret_tag = tag_q[RD_LAT-1];

  logic [7:0] ret_byte;
  logic       take_hi;

  always_comb begin
    take_hi  = ret_tag.lsb ^ BYTE_HI_EVEN;
    ret_byte = model_data;
    if (ret_tag.region == REG_SPEECH) ret_byte = take_hi ? speech_data[15:8] : speech_data[7:0];
  end

  logic [N_CH-1:0]      rvalid_q;
  logic [N_CH-1:0][7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (ret_tag.vld && ret_tag.ch_id == CH_ID_MAX_W'(i)) begin
          rvalid_q[i] <= 1'b1;
          rdata_q[i]  <= ret_byte;
        end
      end
    end
  end

  assign bus.ch_rvalid = rvalid_q;
  assign bus.ch_rdata  = rdata_q;

  logic tag_busy;

  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) tag_busy = tag_busy | tag_q[i].vld;
  end

  assign busy = tag_busy | (|rvalid_q);

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: dut_a (4 ch, RD_LAT=1, round-robin) and
// dut_b (3 ch, RD_LAT=3, fixed priority) against spec-derived expectations.
module tb_shared_ram_arbiter;

  localparam int LA = 1;
  localparam int LB = 3;

  logic clk;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shared_ram_arbiter_if #(.N_CH(4), .AW(21)) ia ();
  shared_ram_arbiter_if #(.N_CH(3), .AW(21)) ib ();

  logic        mrd_a, srd_a, busy_a, mrd_b, srd_b, busy_b;
  logic [19:0] maddr_a, maddr_b;
  logic [18:0] saddr_a, saddr_b;
  logic [7:0]  mdat_a, mdat_b;
  logic [15:0] sdat_a, sdat_b;

  shared_ram_arbiter #(.N_CH(4), .AW(21), .RD_LAT(LA), .RR_MODE(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ia),
    .model_rd(mrd_a), .model_addr(maddr_a), .model_data(mdat_a),
    .speech_rd(srd_a), .speech_addr(saddr_a), .speech_data(sdat_a),
    .busy(busy_a));

  shared_ram_arbiter #(.N_CH(3), .AW(21), .RD_LAT(LB), .RR_MODE(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ib),
    .model_rd(mrd_b), .model_addr(maddr_b), .model_data(mdat_b),
    .speech_rd(srd_b), .speech_addr(saddr_b), .speech_data(sdat_b),
    .busy(busy_b));

  // Memory contents as fixed functions of address
  function automatic logic [7:0] mfun(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  function automatic logic [15:0] sfun(input logic [18:0] w);
    return {w[7:0], w[7:0]} ^ 16'h1137;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [20:0] a);
    logic [15:0] w;
    if (!a[20]) return mfun(a[19:0]);
    w = sfun(a[19:1]);
    return a[0] ? w[7:0] : w[15:8];
  endfunction

  // RAMs with RD_LAT cycles of read latency
  logic [19:0] mp_a [LA];
  logic [18:0] sp_a [LA];
  logic [19:0] mp_b [LB];
  logic [18:0] sp_b [LB];

  always @(posedge clk) begin
    mp_a[0] <= maddr_a;
    sp_a[0] <= saddr_a;
    mp_b[0] <= maddr_b;
    sp_b[0] <= saddr_b;
    for (int i = 1; i < LB; i++) begin
      mp_b[i] <= mp_b[i-1];
      sp_b[i] <= sp_b[i-1];
    end
  end

  assign mdat_a = mfun(mp_a[LA-1]);
  assign sdat_a = sfun(sp_a[LA-1]);
  assign mdat_b = mfun(mp_b[LB-1]);
  assign sdat_b = sfun(sp_b[LB-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          ch;
    logic [20:0] addr;
    logic        mrd;
    logic [19:0] maddr;
    logic        srd;
    logic [18:0] saddr;
    logic [7:0]  data;
  } vec_t;

  typedef struct {
    int         due;
    int         ch;
    logic [7:0] b;
  } pend_t;

  vec_t        vt [6];
  pend_t       pend [$];
  pend_t       pe;
  logic [2:0]  freq [12];
  logic [2:0]  fgnt [12];
  logic [7:0]  eb_b [3];
  logic [3:0]  rq, glast, eg, erv;
  logic [20:0] ra [4];
  logic [7:0]  erd [4];
  logic        emrd, esrd, ebusy;
  logic [19:0] emad;
  logic [18:0] esad;
  logic [2:0]  erv_b;
  int          mp, win, k;

  initial begin
    vt[0] = '{0, 21'h000010, 1'b1, 20'h00010, 1'b0, 19'h0,     8'hA5};
    vt[1] = '{1, 21'h100006, 1'b0, 20'h0,     1'b1, 19'h3,     8'h12};
    vt[2] = '{1, 21'h100007, 1'b0, 20'h0,     1'b1, 19'h3,     8'h34};
    vt[3] = '{2, 21'h0FFFFF, 1'b1, 20'hFFFFF, 1'b0, 19'h0,     8'hB5};
    vt[4] = '{3, 21'h1FFFFE, 1'b0, 20'h0,     1'b1, 19'h7FFFF, 8'hEE};
    vt[5] = '{3, 21'h100000, 1'b0, 20'h0,     1'b1, 19'h0,     8'h11};

    freq = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b100, 3'b011,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    fgnt = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    eb_b = '{8'hB5, 8'h97, 8'h3F};

    ia.ch_req = '0; ia.ch_addr = '0;
    ib.ch_req = '0; ib.ch_addr = '0;
`ifdef SHARED_RAM_ARBITER_BURST_EN
    ia.ch_lock = '0; ib.ch_lock = '0;
`endif
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();
    rst_a = 1'b1; rst_b = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_a gnt",    64'(ia.ch_gnt),    64'(0));
    chk("rst_a rvalid", 64'(ia.ch_rvalid), 64'(0));
    chk("rst_a rdata",  64'(ia.ch_rdata),  64'(0));
    chk("rst_a busy",   64'(busy_a),       64'(0));
    chk("rst_a strobe", 64'({mrd_a, srd_a, maddr_a, saddr_a}), 64'(0));
    chk("rst_b rvalid", 64'(ib.ch_rvalid), 64'(0));
    chk("rst_b busy",   64'(busy_b),       64'(0));
    tick();

    // Single reads, one per vector, with full return latency
    for (int v = 0; v < 6; v++) begin
      ia.ch_req = '0;
      ia.ch_req[vt[v].ch] = 1'b1;
      ia.ch_addr[vt[v].ch*21 +: 21] = vt[v].addr;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", v),   64'(ia.ch_gnt), 64'(4'b0001 << vt[v].ch));
      chk($sformatf("vec%0d mrd", v),   64'(mrd_a),   64'(vt[v].mrd));
      chk($sformatf("vec%0d maddr", v), 64'(maddr_a), 64'(vt[v].maddr));
      chk($sformatf("vec%0d srd", v),   64'(srd_a),   64'(vt[v].srd));
      chk($sformatf("vec%0d saddr", v), 64'(saddr_a), 64'(vt[v].saddr));
      tick();
      ia.ch_req = '0;
      @(negedge clk);
      chk($sformatf("vec%0d early rvalid", v), 64'(ia.ch_rvalid), 64'(0));
      chk($sformatf("vec%0d busy1", v),        64'(busy_a),       64'(1));
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d rvalid", v), 64'(ia.ch_rvalid), 64'(4'b0001 << vt[v].ch));
      chk($sformatf("vec%0d rdata", v),  64'(ia.ch_rdata[vt[v].ch*8 +: 8]), 64'(vt[v].data));
      tick();
    end
    @(negedge clk);
    chk("idle busy_a", 64'(busy_a), 64'(0));
    tick();

    // Round-robin with all four requests held (pointer back at 0)
    for (int ch = 0; ch < 4; ch++) ia.ch_addr[ch*21 +: 21] = 21'h000100 + 21'(ch);
    ia.ch_req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) ia.ch_req = '0;
      @(negedge clk);
      chk($sformatf("rr c%0d gnt", c), 64'(ia.ch_gnt), (c < 5) ? 64'(4'b0001 << (c % 4)) : 64'(0));
      if (c >= 2 && c < 7) begin
        k = (c - 2) % 4;
        chk($sformatf("rr c%0d rvalid", c), 64'(ia.ch_rvalid), 64'(4'b0001 << k));
        chk($sformatf("rr c%0d rdata", c), 64'(ia.ch_rdata[k*8 +: 8]),
            64'(exp_byte(21'h000100 + 21'(k))));
      end else begin
        chk($sformatf("rr c%0d rvalid", c), 64'(ia.ch_rvalid), 64'(0));
      end
      tick();
    end

    // Fixed priority on dut_b, RD_LAT=3
    ib.ch_addr[0*21 +: 21] = 21'h000000;
    ib.ch_addr[1*21 +: 21] = 21'h000123;
    ib.ch_addr[2*21 +: 21] = 21'h100011;
    for (int c = 0; c < 12; c++) begin
      ib.ch_req = freq[c];
      @(negedge clk);
      chk($sformatf("fp c%0d gnt", c), 64'(ib.ch_gnt), 64'(fgnt[c]));
      erv_b = (c >= 4) ? fgnt[c-4] : 3'b000;
      chk($sformatf("fp c%0d rvalid", c), 64'(ib.ch_rvalid), 64'(erv_b));
      for (int ch = 0; ch < 3; ch++)
        if (erv_b[ch]) chk($sformatf("fp c%0d rdata%0d", c, ch), 64'(ib.ch_rdata[ch*8 +: 8]), 64'(eb_b[ch]));
      tick();
    end

    // Reset two cycles after a grant discards the in-flight read
    ib.ch_addr[0*21 +: 21] = 21'h000010;
    ib.ch_req = 3'b001;
    @(negedge clk);
    chk("rstf gnt", 64'(ib.ch_gnt), 64'(3'b001));
    tick();
    ib.ch_req = '0;
    @(negedge clk);
    chk("rstf busy before", 64'(busy_b), 64'(1));
    tick();
    rst_b = 1'b0;
    ib.ch_req = 3'b111;
    @(negedge clk);
    chk("rstf gnt in reset", 64'(ib.ch_gnt), 64'(0));
    tick();
    rst_b = 1'b1;
    ib.ch_req = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstf c%0d rvalid", c), 64'(ib.ch_rvalid), 64'(0));
      chk($sformatf("rstf c%0d busy", c),   64'(busy_b),       64'(0));
      chk($sformatf("rstf c%0d rdata", c),  64'(ib.ch_rdata),  64'(0));
      chk($sformatf("rstf c%0d mrd", c),    64'(mrd_b),        64'(0));
      tick();
    end

    // Randomized traffic on dut_a against a grant/return model
    rst_a = 1'b0; ia.ch_req = '0;
    tick(); tick();
    rst_a = 1'b1;
    rq = '0; glast = '0; mp = 0;
    for (int ch = 0; ch < 4; ch++) begin erd[ch] = 8'h00; ra[ch] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (glast[ch]) begin
          if ($urandom_range(1, 0) == 0) rq[ch] = 1'b0;
          else ra[ch] = 21'($urandom);
        end else if (!rq[ch]) begin
          if ($urandom_range(2, 0) == 0) begin rq[ch] = 1'b1; ra[ch] = 21'($urandom); end
        end else if ($urandom_range(7, 0) == 0) begin
          rq[ch] = 1'b0;
        end
        ia.ch_addr[ch*21 +: 21] = ra[ch];
      end
      ia.ch_req = rq;
      @(negedge clk);
      win = -1;
      for (int i = 0; i < 4; i++) if (win < 0 && rq[(mp + i) % 4]) win = (mp + i) % 4;
      eg = '0; emrd = 1'b0; esrd = 1'b0; emad = '0; esad = '0;
      if (win >= 0) begin
        eg[win] = 1'b1;
        emrd = !ra[win][20];
        esrd = ra[win][20];
        if (emrd) emad = ra[win][19:0];
        if (esrd) esad = ra[win][19:1];
      end
      chk($sformatf("rnd c%0d gnt", c),   64'(ia.ch_gnt), 64'(eg));
      chk($sformatf("rnd c%0d mrd", c),   64'({mrd_a, maddr_a}), 64'({emrd, emad}));
      chk($sformatf("rnd c%0d srd", c),   64'({srd_a, saddr_a}), 64'({esrd, esad}));
      erv = '0;
      ebusy = (pend.size() != 0);
      while (pend.size() != 0 && pend[0].due == c) begin
        pe = pend.pop_front();
        erv[pe.ch] = 1'b1;
        erd[pe.ch] = pe.b;
      end
      chk($sformatf("rnd c%0d rvalid", c), 64'(ia.ch_rvalid), 64'(erv));
      chk($sformatf("rnd c%0d busy", c),   64'(busy_a),       64'(ebusy));
      for (int ch = 0; ch < 4; ch++)
        chk($sformatf("rnd c%0d rdata%0d", c, ch), 64'(ia.ch_rdata[ch*8 +: 8]), 64'(erd[ch]));
      glast = '0;
      if (win >= 0) begin
        pend.push_back('{c + LA + 1, win, exp_byte(ra[win])});
        mp = (win + 1) % 4;
        glast[win] = 1'b1;
      end
      tick();
    end
    ia.ch_req = '0;
    tick(); tick(); tick();

`ifdef SHARED_RAM_ARBITER_BURST_EN
    // Locked owner keeps the port for five cycles, then ch1 is next
    rst_a = 1'b0;
    tick(); tick();
    rst_a = 1'b1;
    for (int c = 0; c < 7; c++) begin
      ia.ch_req  = (c < 5) ? 4'b0011 : ((c == 5) ? 4'b0010 : 4'b0000);
      ia.ch_lock = (c < 5) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk($sformatf("burst c%0d gnt", c), 64'(ia.ch_gnt),
          (c < 5) ? 64'(4'b0001) : ((c == 5) ? 64'(4'b0010) : 64'(0)));
      tick();
    end
    ia.ch_req = '0; ia.ch_lock = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
